// File: rtl/univ_cnt_pkg.sv
// Shared constants and helpers for the universal modulo counter.
package univ_cnt_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Callers zero-extend to 32 bits and truncate the result back to their width.
  function automatic logic [31:0] clamp(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/univ_cnt_step.sv
// Combinational step datapath: candidate next value plus overshoot/undershoot/out-of-range.
module univ_cnt_step
  import univ_cnt_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic [N-1:0]      q,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  output logic [N-1:0]      s,
  output logic              over,
  output logic              under,
  output logic              oor
);

  logic [N:0] q_ext;
  logic [N:0] step_ext;
  logic [N:0] sum;
  logic [N:0] diff;

  assign q_ext    = {1'b0, q};
  assign step_ext = {{(N + 1 - STEP_W){1'b0}}, step};
  assign sum      = q_ext + step_ext;
  assign diff     = q_ext - step_ext;

  // Bit N of diff is the borrow out of the N-bit subtraction.
  assign over  = up && (sum > {1'b0, hi});
  assign under = !up && (diff[N] || (diff[N-1:0] < lo));
  assign s     = up ? sum[N-1:0] : diff[N-1:0];
  assign oor   = (q < lo) || (q > hi);

endmodule

// File: rtl/univ_mod_counter.sv
// Up/down counter with run-time bounds, variable step, wrap/saturate mode and cascade carry.
module univ_mod_counter
  import univ_cnt_pkg::*;
#(
  parameter int          N       = 8,
  parameter int          STEP_W  = 4,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              syn_clr,
  input  logic              load,
  input  logic              en,
  input  logic              up,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [N-1:0]      d,
  output logic [N-1:0]      q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              wrap_tick,
  output logic              sat_flag,
  output logic              carry_out,
  output logic              cfg_err
);

  logic [N-1:0] q_reg, q_next;
  logic         wrap_reg, wrap_next;
  logic         sat_reg, sat_next;

  logic [N-1:0] s;
  logic         over, under, oor;
  logic         step_zero;
  logic         bound_hit;

  univ_cnt_step #(
    .N      (N),
    .STEP_W (STEP_W)
  ) u_step (
    .q     (q_reg),
    .step  (step),
    .up    (up),
    .lo    (lo),
    .hi    (hi),
    .s     (s),
    .over  (over),
    .under (under),
    .oor   (oor)
  );

  assign cfg_err   = lo > hi;
  assign step_zero = (step == '0);
  assign bound_hit = over || under;

  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    sat_next  = 1'b0;
    if (cfg_err) begin
      q_next = q_reg;
    end else if (syn_clr) begin
      q_next = lo;
    end else if (load) begin
      q_next = N'(clamp(32'(d), 32'(lo), 32'(hi)));
    end else if (en) begin
      // Recover into range first when the bounds moved under the counter.
      if (oor) begin
        q_next = up ? lo : hi;
      end else if (step_zero) begin
        q_next = q_reg;
      end else if (bound_hit) begin
        if (mode == MODE_WRAP) begin
          q_next    = up ? lo : hi;
          wrap_next = 1'b1;
        end else begin
          q_next   = up ? hi : lo;
          sat_next = 1'b1;
        end
      end else begin
        q_next = s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg    <= RST_VAL;
      wrap_reg <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
      sat_reg  <= sat_next;
    end
  end

  assign q         = q_reg;
  assign wrap_tick = wrap_reg;
  assign sat_flag  = sat_reg;
  assign max_tick  = (q_reg == hi) && !cfg_err;
  assign min_tick  = (q_reg == lo) && !cfg_err;
  // Predicts exactly the wrap that the next edge will register.
  assign carry_out = en && !cfg_err && !syn_clr && !load && !oor && !step_zero
                     && bound_hit && (mode == MODE_WRAP);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Directed self-checking bench for univ_mod_counter (N=8, STEP_W=4).
module tb_univ_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n, syn_clr, load, en, up, mode;
  logic [3:0] step;
  logic [7:0] lo, hi, d, q;
  logic       max_tick, min_tick, wrap_tick, sat_flag, carry_out, cfg_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  univ_mod_counter #(.N(8), .STEP_W(4), .RST_VAL(8'd0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .syn_clr   (syn_clr),
    .load      (load),
    .en        (en),
    .up        (up),
    .mode      (mode),
    .step      (step),
    .lo        (lo),
    .hi        (hi),
    .d         (d),
    .q         (q),
    .max_tick  (max_tick),
    .min_tick  (min_tick),
    .wrap_tick (wrap_tick),
    .sat_flag  (sat_flag),
    .carry_out (carry_out),
    .cfg_err   (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
      $display("check %-14s observed=%0d expected=%0d ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_val(input logic [7:0] v);
    load = 1'b1; en = 1'b0; d = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
    mode = 1'b0; step = 4'd1; lo = 8'd0; hi = 8'd255; d = 8'd0;
    tick();
    chk("rst_q", q, 0);
    chk("rst_wrap", wrap_tick, 0);
    chk("rst_sat", sat_flag, 0);
    reset_n = 1'b1;

    // 1: reset mid-count
    load_val(8'd37);
    chk("load37", q, 37);
    en = 1'b1; reset_n = 1'b0;
    tick();
    chk("rst2_q", q, 0);
    chk("rst2_wrap", wrap_tick, 0);
    chk("rst2_sat", sat_flag, 0);
    reset_n = 1'b1; en = 1'b0;

    // plain count
    en = 1'b1; step = 4'd2;
    tick();
    chk("cnt_up2", q, 2);
    chk("cnt_nowrap", wrap_tick, 0);

    // 2: wrap up
    lo = 8'd3; hi = 8'd10;
    load_val(8'd9);
    chk("load9", q, 9);
    en = 1'b1; up = 1'b1; step = 4'd3; mode = 1'b0;
    #1;
    chk("carry_pred", carry_out, 1);
    tick();
    chk("wrap_q", q, 3);
    chk("wrap_tick", wrap_tick, 1);
    chk("wrap_min", min_tick, 1);
    en = 1'b0;
    tick();
    chk("wrap_pulse", wrap_tick, 0);
    chk("wrap_hold", q, 3);

    // 3: saturate down
    load_val(8'd6);
    en = 1'b1; mode = 1'b1; up = 1'b0; step = 4'd5;
    #1;
    chk("sat_nocarry", carry_out, 0);
    tick();
    chk("sat_q1", q, 3);
    chk("sat_flag1", sat_flag, 1);
    tick();
    chk("sat_q2", q, 3);
    chk("sat_flag2", sat_flag, 1);
    en = 1'b0;
    tick();
    chk("sat_clear", sat_flag, 0);

    // 4: priority clear > load > count, then clamped load
    lo = 8'd4; hi = 8'd10; up = 1'b1; mode = 1'b0; step = 4'd1;
    syn_clr = 1'b1; load = 1'b1; en = 1'b1; d = 8'd9;
    tick();
    chk("prio_clr", q, 4);
    syn_clr = 1'b0; en = 1'b0; d = 8'd200;
    tick();
    load = 1'b0;
    chk("load_clamp", q, 10);
    chk("max_tick", max_tick, 1);

    // 5: bounds change, then illegal config
    lo = 8'd0; hi = 8'd255;
    load_val(8'd50);
    lo = 8'd5; hi = 8'd20; en = 1'b1; up = 1'b1; step = 4'd1;
    #1;
    chk("oor_nocarry", carry_out, 0);
    tick();
    chk("oor_q", q, 5);
    chk("oor_notick", wrap_tick, 0);
    lo = 8'd30; load = 1'b1; d = 8'd25;
    #1;
    chk("cfg_err", cfg_err, 1);
    chk("cfg_min", min_tick, 0);
    tick();
    chk("cfg_frozen", q, 5);
    chk("cfg_flags", wrap_tick | sat_flag, 0);
    load = 1'b0; en = 1'b0;

    // 6: full-range wrap both ways
    lo = 8'd0; hi = 8'd255;
    load_val(8'd255);
    en = 1'b1; up = 1'b1; step = 4'd1; mode = 1'b0;
    tick();
    chk("full_up_q", q, 0);
    chk("full_up_w", wrap_tick, 1);
    up = 1'b0;
    tick();
    chk("full_dn_q", q, 255);
    chk("full_dn_w", wrap_tick, 1);

    // lo==hi: every enabled cycle wraps (WRAP) or saturates (SAT)
    lo = 8'd7; hi = 8'd7; en = 1'b0; syn_clr = 1'b1;
    tick();
    syn_clr = 1'b0;
    chk("eq_clr", q, 7);
    en = 1'b1; up = 1'b1;
    tick();
    chk("eq_wrap", wrap_tick, 1);
    mode = 1'b1;
    tick();
    chk("eq_sat", sat_flag, 1);
    chk("eq_satq", q, 7);
    step = 4'd0;
    tick();
    chk("step0_flag", sat_flag, 0);
    en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
